// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/strobe front end.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int GLITCH_CNT_W    = 8;

endpackage

// File: rtl/debounce_strobe_gen_if.sv
// Signal bundle between a bouncing source and the debounced latch drive.
// glitch_cnt exists only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface debounce_strobe_gen_if;

  logic raw_in;
  logic d_out;
  logic en_out;
  logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [debounce_pkg::GLITCH_CNT_W-1:0] glitch_cnt;
`endif

  modport master (
    output raw_in,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    input  glitch_cnt,
`endif
    input  d_out,
    input  en_out,
    input  busy
  );

  modport slave (
    input  raw_in,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output glitch_cnt,
`endif
    output d_out,
    output en_out,
    output busy
  );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; all flops reset to 0.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_strobe_gen.sv
// Synchronise and debounce a bouncing input; strobe en_out once per accepted change.
// Optional abort counter on glitch_cnt with DEBOUNCE_GLITCH_CNT_EN defined.
//
//   state     | meaning
//   IDLE_LOW  | d_out=0, waiting for sync to go high
//   WAIT_HIGH | sync high, counting stable cycles before accepting 1
//   IDLE_HIGH | d_out=1, waiting for sync to go low
//   WAIT_LOW  | sync low, counting stable cycles before accepting 0
module debounce_strobe_gen
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input logic                 clk,
  input logic                 rst,
  debounce_strobe_gen_if.slave bus
);

  if (SYNC_STAGES != 2 && SYNC_STAGES != 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must lie in 1 .. 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;
  logic             en_q, en_d;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.raw_in),
    .q   (sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      en_q    <= en_d;
    end
  end

  // Completion needs sync still at the target level, so a reversion always aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    en_d    = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          d_d     = 1'b1;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          d_d     = 1'b0;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.d_out  = d_q;
  assign bus.en_out = en_q;
  assign bus.busy   = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_q;

  assign abort = ((state_q == WAIT_HIGH) && !sync) || ((state_q == WAIT_LOW) && sync);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (abort && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_debounce_strobe_gen.sv
// Directed bench: DUT a (S=2, D=4, CNT_W=4) driven from a vector table, DUT b (D=1) by hand.
module tb_debounce_strobe_gen;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  debounce_strobe_gen_if bus_a ();
  debounce_strobe_gen_if bus_b ();

  debounce_strobe_gen #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE_CYCLES(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  debounce_strobe_gen #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE_CYCLES(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic raw;
    logic exp_d;
    logic exp_en;
    logic exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic raw, input logic d, input logic en, input logic b);
    vec_t v;
    v.rst = r; v.raw = raw; v.exp_d = d; v.exp_en = en; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic d, input logic en, input logic b);
    chk({tag, " a.d_out"},  int'(bus_a.d_out),  int'(d));
    chk({tag, " a.en_out"}, int'(bus_a.en_out), int'(en));
    chk({tag, " a.busy"},   int'(bus_a.busy),   int'(b));
  endtask

  task automatic chk_b(input string tag, input logic d, input logic en, input logic b);
    chk({tag, " b.d_out"},  int'(bus_b.d_out),  int'(d));
    chk({tag, " b.en_out"}, int'(bus_b.en_out), int'(en));
    chk({tag, " b.busy"},   int'(bus_b.busy),   int'(b));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_a.raw_in = 1'b0;
    bus_b.raw_in = 1'b0;

    // reset held with input high
    for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    // rise held: accepted on edge 7
    add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 1);
    add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 1); add(0, 1, 1, 1, 0); add(0, 1, 1, 0, 0);
    // fall held: accepted on edge 7
    add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1); add(0, 0, 1, 0, 1); add(0, 0, 0, 1, 0); add(0, 0, 0, 0, 0);
    // three-sample glitch
    add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 1); add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    // reversion on the edge that would have completed
    add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 1); add(0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 0);
    // toggle every cycle
    add(0, 1, 0, 0, 0); add(0, 0, 0, 0, 0); add(0, 1, 0, 0, 1); add(0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1); add(0, 0, 0, 0, 0); add(0, 0, 0, 0, 1); add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      bus_a.raw_in = vecs[i].raw;
      @(posedge clk);
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_en, vecs[i].exp_busy);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("a.glitch_cnt after table", int'(bus_a.glitch_cnt), 5);
`endif

    // reset pulse while WAIT_HIGH with cnt=2
    bus_a.raw_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("pre-rst a.busy", int'(bus_a.busy), 1);
    rst = 1'b1;
    #1;
    chk_a("async rst", 0, 0, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("rst a.glitch_cnt", int'(bus_a.glitch_cnt), 0);
`endif
    @(posedge clk);
    #1;
    chk_a("rst held", 0, 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk_a($sformatf("post-rst e%0d", k), k >= 7, k == 7, (k >= 3) && (k <= 6));
    end

    // DEBOUNCE_CYCLES=1: rise accepted on edge 4
    bus_b.raw_in = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk_b($sformatf("d1 rise e%0d", k), k >= 4, k == 4, k == 3);
    end
    // one-sample low glitch from d_out=1 aborts
    for (int k = 1; k <= 6; k++) begin
      bus_b.raw_in = (k == 1) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      chk_b($sformatf("d1 glitch e%0d", k), 1, 0, k == 3);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("b.glitch_cnt", int'(bus_b.glitch_cnt), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
